mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 64, meaning address width.
REQ-002 The block SHALL have parameter DW, default 64, meaning data width.
REQ-003 The block SHALL have parameter STARVE_LIM, default 4, meaning the maximum number of consecutive cycles an external request waits behind the core (legal range 1..15).
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core load/store request (MemRead|MemWrite).
- c_we  in  1  core write enable.
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data.
- c_stall  out  1  core must hold PC and the current instruction.
- c_rdata  out  DW  core read data.
- x_req  in  1  external (loader/debug) request.
- x_we  in  1  external write enable.
- x_lock  in  1  external keeps ownership for a burst.
- x_addr  in  AW  external address.
- x_wdata  in  DW  external write data.
- x_gnt  out  1  external access performed this cycle.
- x_rdata  out  DW  external read data.
- m_re  out  1  memory read enable.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory combinational read data.

Function
REQ-005 Grant SHALL be combinational from the current state and requests; exactly one requester or none is granted per cycle.
REQ-006 State SHALL be the register owner ∈ {IDLE, CORE, EXT, LOCK} plus a 4-bit wait counter wcnt.
REQ-007 Grant priority SHALL be: (a) owner==LOCK and x_req -> EXT; (b) x_req and wcnt>=STARVE_LIM -> EXT; (c) c_req -> CORE; (d) x_req -> EXT; (e) otherwise none.
REQ-008 When EXT is granted: m_* SHALL mirror x_*, m_re = ~x_we, x_gnt=1, and c_stall=c_req.
REQ-009 When CORE is granted: m_* SHALL mirror c_*, m_re = ~c_we, x_gnt=0, and c_stall=0.
REQ-010 When nothing is granted: m_re=m_we=0, x_gnt=0, c_stall=0, and m_addr/m_wdata=0.
REQ-011 c_rdata and x_rdata SHALL both equal m_rdata (same cycle); data is valid only for the granted side.
REQ-012 The next owner SHALL be: LOCK if EXT is granted with x_lock=1; EXT if EXT is granted with x_lock=0; CORE if CORE is granted; IDLE otherwise. LOCK with x_req=0 SHALL release to IDLE the next cycle.
REQ-013 wcnt SHALL increment (saturating at 15) each cycle x_req=1 and EXT is not granted, and SHALL clear on EXT grant or when x_req=0.
REQ-014 Requesters SHALL hold their request fields stable while stalled or not granted; the arbiter SHALL NOT latch request data.
REQ-015 x_lock asserted while owner!=LOCK SHALL NOT preempt the core; the lock takes effect only after the first EXT grant.

Reset
REQ-016 With rst=1 at a clock edge: owner=IDLE, wcnt=0; rst SHALL take priority over every other event, including mid-lock.
REQ-017 During reset cycles outputs SHALL follow REQ-007..011 from reset state; after reset, with no requests, c_stall=0, x_gnt=0, m_re=m_we=0.

Configuration
REQ-018 With macro MEM_ARBITER_STATS_EN defined: 32-bit output stall_cnt SHALL exist, counting cycles with c_stall=1, saturating at 0xFFFFFFFF, and cleared by rst.
REQ-019 Without MEM_ARBITER_STATS_EN: stall_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-020 Core only: c_req=1, c_we=1, c_addr=0x10, c_wdata=0xAA -> m_we=1, m_addr=0x10, c_stall=0, x_gnt=0.
REQ-021 Contention with STARVE_LIM=4: c_req and x_req held high -> core wins 4 cycles, EXT granted in cycle 5 with c_stall=1, core wins in cycle 6.
REQ-022 Lock burst: x_req=1 and x_lock=1 for 3 cycles while c_req=1 -> after the first EXT grant, EXT is held and c_stall=1 throughout; when x_req drops, core is granted the next cycle.
REQ-023 Reset mid-lock: rst=1 while owner=LOCK -> next cycle owner=IDLE, and with c_req=1 the core is granted.
REQ-024 External read: x_req=1, x_we=0, x_addr=0x20, m_rdata=0x1234 -> m_re=1, x_gnt=1, x_rdata=0x1234.
REQ-025 STATS_EN: 7 stall cycles -> stall_cnt=7; after rst, stall_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the core load/store path and an external loader/debug port.
// Optional stall statistics counter enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_stall,
    output logic [DW-1:0] c_rdata,
    input  logic          x_req,
    input  logic          x_we,
    input  logic          x_lock,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic [DW-1:0] x_rdata,
    output logic          m_re,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2,
        OWN_LOCK = 2'd3
    } owner_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    owner_t     r_owner;
    owner_t     w_owner_nxt;
    logic [3:0] r_wcnt;
    logic [3:0] w_wcnt_nxt;
    logic       w_gnt_ext;
    logic       w_gnt_core;

    // Grant decision: lock hold, starvation escape, core priority, then external.
    always_comb begin
        w_gnt_ext  = 1'b0;
        w_gnt_core = 1'b0;
        if (r_owner == OWN_LOCK && x_req) begin
            w_gnt_ext = 1'b1;
        end else if (x_req && (r_wcnt >= LIM)) begin
            w_gnt_ext = 1'b1;
        end else if (c_req) begin
            w_gnt_core = 1'b1;
        end else if (x_req) begin
            w_gnt_ext = 1'b1;
        end else begin
            w_gnt_ext  = 1'b0;
            w_gnt_core = 1'b0;
        end
    end

    // Next owner and starvation counter; a lock only forms after an actual external grant.
    always_comb begin
        w_owner_nxt = OWN_IDLE;
        w_wcnt_nxt  = 4'd0;
        if (w_gnt_ext) begin
            w_owner_nxt = x_lock ? OWN_LOCK : OWN_EXT;
        end else if (w_gnt_core) begin
            w_owner_nxt = OWN_CORE;
        end else begin
            w_owner_nxt = OWN_IDLE;
        end
        if (x_req && !w_gnt_ext) begin
            w_wcnt_nxt = (r_wcnt == 4'd15) ? 4'd15 : (r_wcnt + 4'd1);
        end else begin
            w_wcnt_nxt = 4'd0;
        end
    end

    // Memory-side mux; address and data are forced to zero when idle.
    always_comb begin
        m_re    = 1'b0;
        m_we    = 1'b0;
        m_addr  = {AW{1'b0}};
        m_wdata = {DW{1'b0}};
        x_gnt   = 1'b0;
        c_stall = 1'b0;
        if (w_gnt_ext) begin
            m_re    = ~x_we;
            m_we    = x_we;
            m_addr  = x_addr;
            m_wdata = x_wdata;
            x_gnt   = 1'b1;
            c_stall = c_req;
        end else if (w_gnt_core) begin
            m_re    = ~c_we;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else begin
            m_re    = 1'b0;
            m_we    = 1'b0;
        end
    end

    assign c_rdata = m_rdata;
    assign x_rdata = m_rdata;

    // Owner/wait-counter state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_owner <= w_owner_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of core stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (c_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model (locked flag + wait count).
module tb_mem_arbiter;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, x_req, x_we, x_lock;
    logic [AW-1:0] c_addr, x_addr;
    logic [DW-1:0] c_wdata, x_wdata, m_rdata;
    logic          c_stall, x_gnt, m_re, m_we;
    logic [DW-1:0] c_rdata, x_rdata, m_wdata;
    logic [AW-1:0] m_addr;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_stall(c_stall), .c_rdata(c_rdata),
        .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_gnt(x_gnt), .x_rdata(x_rdata),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef MEM_ARBITER_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: "external currently holds a lock" and "cycles external has waited".
    bit            mdl_locked = 1'b0;
    int            mdl_wait   = 0;
    logic [31:0]   mdl_stalls = 32'd0;
    bit            mdl_ext, mdl_core;
    logic          e_xg, e_cs, e_re, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;

    task automatic predict();
        mdl_ext  = x_req && (mdl_locked || (mdl_wait >= LIM));
        if (!mdl_ext && !c_req && x_req) mdl_ext = 1'b1;
        mdl_core = !mdl_ext && c_req;
        e_xg = mdl_ext;
        e_cs = mdl_ext && c_req;
        e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (mdl_ext) begin
            e_re = !x_we; e_we = x_we; e_addr = x_addr; e_wd = x_wdata;
        end else if (mdl_core) begin
            e_re = !c_we; e_we = c_we; e_addr = c_addr; e_wd = c_wdata;
        end
    endtask

    task automatic advance();
        if (rst) begin
            mdl_locked = 1'b0;
            mdl_wait   = 0;
            mdl_stalls = 32'd0;
        end else begin
            if (e_cs && mdl_stalls != 32'hFFFF_FFFF) mdl_stalls = mdl_stalls + 32'd1;
            mdl_locked = mdl_ext && x_lock;
            mdl_wait   = (x_req && !mdl_ext) ? ((mdl_wait < 15) ? mdl_wait + 1 : 15) : 0;
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        x_req = 1'b0; x_we = 1'b0; x_lock = 1'b0; x_addr = '0; x_wdata = '0; m_rdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk); set_idle(); rst = 1'b1;
        @(posedge clk); advance();
        @(negedge clk); #1; predict();
        n_cmp++;
        if ({x_gnt, c_stall, m_re, m_we, m_addr} !== {4'b0000, {AW{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_outputs: got gnt=%b stall=%b re=%b we=%b addr=%h, want all zero",
                     x_gnt, c_stall, m_re, m_we, m_addr);
        end
        @(posedge clk); advance();
        @(negedge clk); rst = 1'b0; #1; predict();
        n_cmp++;
        if ({x_gnt, c_stall, m_re, m_we} !== 4'b0000) begin
            n_bad++;
            $display("FAIL post_reset_idle: got gnt=%b stall=%b re=%b we=%b, want 0000",
                     x_gnt, c_stall, m_re, m_we);
        end
`ifdef MEM_ARBITER_STATS_EN
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        @(posedge clk); advance();
    endtask

    task automatic test_core_only();
        @(negedge clk); set_idle();
        c_req = 1'b1; c_we = 1'b1; c_addr = 64'h10; c_wdata = 64'hAA;
        #1; predict();
        n_cmp++;
        if ({m_we, m_re, x_gnt, c_stall} !== 4'b1000 || m_addr !== 64'h10 || m_wdata !== 64'hAA) begin
            n_bad++;
            $display("FAIL core_write: got we=%b re=%b gnt=%b stall=%b addr=%h wdata=%h, want 1 0 0 0 10 aa",
                     m_we, m_re, x_gnt, c_stall, m_addr, m_wdata);
        end
        @(posedge clk); advance();
    endtask

    task automatic test_contention();
        @(negedge clk); set_idle(); #1; predict();
        @(posedge clk); advance();
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 1'b0; c_addr = {$urandom, $urandom};
            x_req = 1'b1; x_we = 1'b1; x_addr = {$urandom, $urandom}; x_wdata = {$urandom, $urandom};
            #1; predict();
            n_cmp++;
            if ({x_gnt, c_stall} !== ((cyc == 5) ? 2'b11 : 2'b00)) begin
                n_bad++;
                $display("FAIL contention_c%0d: got gnt=%b stall=%b, want %b", cyc, x_gnt, c_stall, (cyc == 5));
            end
            @(posedge clk); advance();
        end
    endtask

    task automatic test_lock_burst();
        int waited = 0;
        bit got = 1'b0;
        @(negedge clk); set_idle(); #1; predict();
        @(posedge clk); advance();
        while (!got && waited < 20) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 1'b1; c_addr = 64'h300; c_wdata = 64'h55;
            x_req = 1'b1; x_lock = 1'b1; x_we = 1'b1; x_addr = 64'h400; x_wdata = {$urandom, $urandom};
            #1; predict();
            waited++;
            if (x_gnt === 1'b1) got = 1'b1;
            @(posedge clk); advance();
        end
        n_cmp++;
        if (!got || waited != LIM + 1) begin
            n_bad++;
            $display("FAIL lock_first_grant: granted=%b after %0d cycles, want grant on cycle %0d", got, waited, LIM + 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); x_wdata = {$urandom, $urandom}; #1; predict();
            n_cmp++;
            if ({x_gnt, c_stall} !== 2'b11 || m_wdata !== x_wdata) begin
                n_bad++;
                $display("FAIL lock_hold_%0d: got gnt=%b stall=%b wdata=%h, want 1 1 %h", i, x_gnt, c_stall, m_wdata, x_wdata);
            end
            @(posedge clk); advance();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); x_req = 1'b0; #1; predict();
            n_cmp++;
            if ({x_gnt, c_stall, m_we} !== 3'b001 || m_addr !== 64'h300) begin
                n_bad++;
                $display("FAIL lock_release_%0d: got gnt=%b stall=%b we=%b addr=%h, want 0 0 1 300",
                         i, x_gnt, c_stall, m_we, m_addr);
            end
            @(posedge clk); advance();
        end
    endtask

    task automatic test_reset_mid_lock();
        @(negedge clk); set_idle(); x_req = 1'b1; x_lock = 1'b1; x_we = 1'b1; #1; predict();
        n_cmp++;
        if (x_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL midlock_enter: got gnt=%b want 1", x_gnt);
        end
        @(posedge clk); advance();
        @(negedge clk); rst = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 64'h77; #1; predict();
        @(posedge clk); advance();
        @(negedge clk); rst = 1'b0; #1; predict();
        n_cmp++;
        if ({x_gnt, c_stall, m_re} !== 3'b001 || m_addr !== 64'h77) begin
            n_bad++;
            $display("FAIL midlock_reset: got gnt=%b stall=%b re=%b addr=%h, want 0 0 1 77", x_gnt, c_stall, m_re, m_addr);
        end
        @(posedge clk); advance();
    endtask

    task automatic test_ext_read();
        @(negedge clk); set_idle();
        x_req = 1'b1; x_we = 1'b0; x_addr = 64'h20; m_rdata = 64'h1234;
        #1; predict();
        n_cmp++;
        if ({m_re, m_we, x_gnt} !== 3'b101 || x_rdata !== 64'h1234 || m_addr !== 64'h20) begin
            n_bad++;
            $display("FAIL ext_read: got re=%b we=%b gnt=%b rdata=%h addr=%h, want 1 0 1 1234 20",
                     m_re, m_we, x_gnt, x_rdata, m_addr);
        end
        @(posedge clk); advance();
    endtask

    task automatic test_stats();
`ifdef MEM_ARBITER_STATS_EN
        @(negedge clk); set_idle(); rst = 1'b1; #1; predict();
        @(posedge clk); advance();
        @(negedge clk); rst = 1'b0; x_req = 1'b1; x_lock = 1'b1; #1; predict();
        @(posedge clk); advance();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); c_req = 1'b1; #1; predict();
            @(posedge clk); advance();
        end
        @(negedge clk); set_idle(); #1; predict();
        n_cmp++;
        if (stall_cnt !== 32'd7) begin
            n_bad++;
            $display("FAIL stats_count: got %0d want 7", stall_cnt);
        end
        @(posedge clk); advance();
        @(negedge clk); rst = 1'b1; #1; predict();
        @(posedge clk); advance();
        @(negedge clk); rst = 1'b0; #1; predict();
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL stats_clear: got %0d want 0", stall_cnt);
        end
        @(posedge clk); advance();
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 39) == 0);
            c_req   = ($urandom_range(0, 3) != 0);
            c_we    = $urandom_range(0, 1);
            c_addr  = {$urandom, $urandom};
            c_wdata = {$urandom, $urandom};
            x_req   = ($urandom_range(0, 2) != 0);
            x_we    = $urandom_range(0, 1);
            x_lock  = ($urandom_range(0, 3) == 0);
            x_addr  = {$urandom, $urandom};
            x_wdata = {$urandom, $urandom};
            m_rdata = {$urandom, $urandom};
            #1; predict();
            n_cmp++;
            if ({x_gnt, c_stall, m_re, m_we, m_addr, m_wdata, c_rdata, x_rdata}
                !== {e_xg, e_cs, e_re, e_we, e_addr, e_wd, m_rdata, m_rdata}) begin
                n_bad++;
                $display("FAIL random_%0d: got gnt=%b stall=%b re=%b we=%b addr=%h wd=%h crd=%h xrd=%h, want %b %b %b %b %h %h %h",
                         i, x_gnt, c_stall, m_re, m_we, m_addr, m_wdata, c_rdata, x_rdata,
                         e_xg, e_cs, e_re, e_we, e_addr, e_wd, m_rdata);
            end
`ifdef MEM_ARBITER_STATS_EN
            n_cmp++;
            if (stall_cnt !== mdl_stalls) begin
                n_bad++;
                $display("FAIL random_stats_%0d: got %0d want %0d", i, stall_cnt, mdl_stalls);
            end
`endif
            @(posedge clk); advance();
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_core_only();
        test_contention();
        test_lock_burst();
        test_reset_mid_lock();
        test_ext_read();
        test_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
